stopwatch_timer: RTL

Parametrised stopwatch/countdown core for the board-level timing designs: a programmable prescaler turns the system clock into 1 ms ticks that advance a min:sec:ms value, either counting up with wrap-around or counting down from a loaded preset to zero. It adds lap capture, event pulses and exact modulo arithmetic, and feeds the display/multiplexer logic directly.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/stopwatch_timer_if.sv | 38 +++
 rtl/stopwatch_timer_tick_gen.sv | 30 +++
 rtl/stopwatch_timer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants, field widths, mode encoding and divisor helpers for the stopwatch core.
// No logic; evaluated at elaboration only.
// No flow control.
package stopwatch_pkg;

    localparam int MS_W  = 10;
    localparam int SEC_W = 6;

    localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_e;

    // Prescaler divisor; callers are expected to pick an exact integer ratio of at least 2.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int min_width(input int min_max);
        return (min_max < 1) ? 1 : $clog2(min_max + 1);
    endfunction

endpackage

// File: rtl/stopwatch_timer_if.sv
// Control and time-value bundle between the stopwatch core and its user.
// Pure wiring, zero latency.
// No backpressure: controls are levels or one-cycle pulses, outputs are registered levels/pulses.
interface stopwatch_timer_if
    import stopwatch_pkg::*;
#(
    parameter int MW = 6
);
    logic             run;
    logic             clear;
    logic             mode;
    logic             load;
    logic [MW-1:0]    preset_min;
    logic [SEC_W-1:0] preset_sec;
    logic             lap;

    logic [MS_W-1:0]  ms;
    logic [SEC_W-1:0] sec;
    logic [MW-1:0]    min;
    logic [MS_W-1:0]  lap_ms;
    logic [SEC_W-1:0] lap_sec;
    logic [MW-1:0]    lap_min;
    logic             lap_valid;
    logic             tick;
    logic             wrap;
    logic             done;

    modport master (
        output run, clear, mode, load, preset_min, preset_sec, lap,
        input  ms, sec, min, lap_ms, lap_sec, lap_min, lap_valid, tick, wrap, done
    );

    modport slave (
        input  run, clear, mode, load, preset_min, preset_sec, lap,
        output ms, sec, min, lap_ms, lap_sec, lap_min, lap_valid, tick, wrap, done
    );

endinterface

// File: rtl/stopwatch_timer_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last count as a step.
// step is combinational from the count; the counter wraps on the same edge.
// Disabled = hold (fractional period preserved); clr zeroes the count and wins over en.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);
    localparam int             CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign step = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch/countdown: min:sec:ms advanced by prescaled 1 ms steps, with lap capture and event pulses.
// New time, tick, wrap and done appear one cycle after the stepping edge; clear/load act on the next edge.
// No backpressure; run=0 holds all state, down-count freezes at zero until clear or load.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int MIN_MAX = 59
) (
    input  logic           clk,
    input  logic           rst,
    stopwatch_timer_if.slave sw
);
    localparam int            DIV     = calc_div(CLK_HZ, TICK_HZ);
    localparam int            MW      = min_width(MIN_MAX);
    localparam logic [MW-1:0] MIN_TOP = MW'(MIN_MAX);

    logic [MS_W-1:0]  ms_q, lap_ms_q, nxt_ms;
    logic [SEC_W-1:0] sec_q, lap_sec_q, nxt_sec;
    logic [MW-1:0]    min_q, lap_min_q, nxt_min;
    logic             lap_valid_q, tick_q, wrap_q, done_q, expired_q;
    logic             nxt_wrap, nxt_done;
    logic [MW-1:0]    ld_min;
    logic [SEC_W-1:0] ld_sec;
    logic             down, is_zero, frozen, step;

    assign down    = (mode_e'(sw.mode) == MODE_DOWN);
    assign is_zero = (ms_q == '0) && (sec_q == '0) && (min_q == '0);
    // Down-count never steps from zero, whether it got there by expiring or was simply sitting there.
    assign frozen  = down && (expired_q || is_zero);

    assign ld_min = (sw.preset_min > MIN_TOP) ? MIN_TOP : sw.preset_min;
    assign ld_sec = (sw.preset_sec > SEC_MAX) ? SEC_MAX : sw.preset_sec;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (sw.run && !frozen),
        .clr  (sw.clear || sw.load),
        .step (step)
    );

    always_comb begin
        nxt_ms   = ms_q;
        nxt_sec  = sec_q;
        nxt_min  = min_q;
        nxt_wrap = 1'b0;
        nxt_done = 1'b0;
        if (!down) begin
            if (ms_q != MS_MAX) begin
                nxt_ms = ms_q + MS_W'(1);
            end else begin
                nxt_ms = '0;
                if (sec_q != SEC_MAX) begin
                    nxt_sec = sec_q + SEC_W'(1);
                end else begin
                    nxt_sec = '0;
                    if (min_q != MIN_TOP) begin
                        nxt_min = min_q + MW'(1);
                    end else begin
                        nxt_min  = '0;
                        nxt_wrap = 1'b1;
                    end
                end
            end
        end else begin
            if (ms_q != '0) begin
                nxt_ms = ms_q - MS_W'(1);
            end else begin
                nxt_ms = MS_MAX;
                if (sec_q != '0) begin
                    nxt_sec = sec_q - SEC_W'(1);
                end else begin
                    nxt_sec = SEC_MAX;
                    nxt_min = min_q - MW'(1);
                end
            end
            nxt_done = (ms_q == MS_W'(1)) && (sec_q == '0) && (min_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_q        <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            lap_ms_q    <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_valid_q <= 1'b0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;

            // Lap samples the pre-update time; a coincident clear/load below still drops lap_valid.
            if (sw.lap) begin
                lap_ms_q    <= ms_q;
                lap_sec_q   <= sec_q;
                lap_min_q   <= min_q;
                lap_valid_q <= 1'b1;
            end

            if (sw.clear) begin
                ms_q        <= '0;
                sec_q       <= '0;
                min_q       <= '0;
                expired_q   <= 1'b0;
                lap_valid_q <= 1'b0;
            end else if (sw.load) begin
                ms_q        <= '0;
                sec_q       <= ld_sec;
                min_q       <= ld_min;
                expired_q   <= down && (ld_sec == '0) && (ld_min == '0);
                lap_valid_q <= 1'b0;
            end else if (step) begin
                ms_q      <= nxt_ms;
                sec_q     <= nxt_sec;
                min_q     <= nxt_min;
                tick_q    <= 1'b1;
                wrap_q    <= nxt_wrap;
                done_q    <= nxt_done;
                // An up step leaves zero, so a stale expiry no longer applies.
                expired_q <= nxt_done;
            end
        end
    end

    assign sw.ms        = ms_q;
    assign sw.sec       = sec_q;
    assign sw.min       = min_q;
    assign sw.lap_ms    = lap_ms_q;
    assign sw.lap_sec   = lap_sec_q;
    assign sw.lap_min   = lap_min_q;
    assign sw.lap_valid = lap_valid_q;
    assign sw.tick      = tick_q;
    assign sw.wrap      = wrap_q;
    assign sw.done      = done_q;

endmodule
